// File: rtl/trdb_pkg.sv
// Shared types for the trace encoder: lifecycle FSM states and sync request reasons.
package trdb_pkg;

    typedef enum logic [2:0] {
        LC_IDLE        = 3'd0,
        LC_START_PEND  = 3'd1,
        LC_TRACING     = 3'd2,
        LC_RESYNC_PEND = 3'd3,
        LC_STOP_PEND   = 3'd4
    } lc_state_e;

    typedef enum logic [1:0] {
        REASON_START   = 2'd0,
        REASON_RESYNC  = 2'd1,
        REASON_STOP    = 2'd2,
        REASON_DISABLE = 2'd3
    } lc_reason_e;

    localparam int unsigned RESYNC_W_DEFAULT = 16;

    function automatic logic lc_is_pending(input lc_state_e s);
        return (s == LC_START_PEND) || (s == LC_RESYNC_PEND) || (s == LC_STOP_PEND);
    endfunction

endpackage

// File: rtl/trdb_lifecycle.sv
// Tracing lifecycle controller: turns qualification transitions into start/resync/stop
// sync requests over valid/ready, and counts retired instructions for periodic resync.
module trdb_lifecycle
    import trdb_pkg::*;
#(
    parameter int unsigned RESYNC_W = RESYNC_W_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                nc_trace_qualified_i,
    input  logic                trace_enable_i,
    input  logic                inst_valid_i,
    input  logic [RESYNC_W-1:0] resync_max_i,
    output logic                sync_valid_o,
    input  logic                sync_ready_i,
    output logic [1:0]          sync_reason_o,
    output logic                tracing_o,
    output logic [RESYNC_W-1:0] resync_cnt_o
);

    lc_state_e             state_q, state_d;
    lc_reason_e            stop_reason_q, stop_reason_d;
    lc_reason_e            sync_reason_q, sync_reason_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  sync_valid_q;
    logic                  tracing_q;
    logic [RESYNC_W-1:0]   resync_cnt_q;

    logic                  handshake;
    logic                  resync_hit;
    lc_reason_e            drop_reason;
    logic                  cnt_clear;
    logic                  cnt_inc;

    assign handshake   = sync_valid_q & sync_ready_i;
    // >= so that lowering the threshold below the running count still triggers a resync
    assign resync_hit  = (resync_max_i != '0) && (resync_cnt_q >= resync_max_i);
    assign drop_reason = trace_enable_i ? REASON_STOP : REASON_DISABLE;

    always_comb begin
        state_d       = state_q;
        stop_pend_d   = stop_pend_q;
        stop_reason_d = stop_reason_q;
        sync_reason_d = REASON_START;

        unique case (state_q)
            LC_IDLE: begin
                if (nc_trace_qualified_i) state_d = LC_START_PEND;
            end
            LC_START_PEND: begin
                if (handshake) state_d = LC_TRACING;
            end
            LC_TRACING: begin
                if (!nc_trace_qualified_i) begin
                    state_d       = LC_STOP_PEND;
                    stop_reason_d = drop_reason;
                end else if (resync_hit) begin
                    state_d = LC_RESYNC_PEND;
                end
            end
            LC_RESYNC_PEND: begin
                // A drop here is remembered but must not disturb the in-flight RESYNC payload
                if (!nc_trace_qualified_i && !stop_pend_q) begin
                    stop_pend_d   = 1'b1;
                    stop_reason_d = drop_reason;
                end
                if (handshake) state_d = stop_pend_d ? LC_STOP_PEND : LC_TRACING;
            end
            LC_STOP_PEND: begin
                if (handshake) begin
                    state_d     = LC_IDLE;
                    stop_pend_d = 1'b0;
                end
            end
            default: state_d = LC_IDLE;
        endcase

        unique case (state_d)
            LC_RESYNC_PEND: sync_reason_d = REASON_RESYNC;
            LC_STOP_PEND:   sync_reason_d = stop_reason_d;
            default:        sync_reason_d = REASON_START;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= LC_IDLE;
            stop_pend_q   <= 1'b0;
            stop_reason_q <= REASON_STOP;
            sync_valid_q  <= 1'b0;
            sync_reason_q <= REASON_START;
            tracing_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            stop_pend_q   <= stop_pend_d;
            stop_reason_q <= stop_reason_d;
            sync_valid_q  <= lc_is_pending(state_d);
            sync_reason_q <= sync_reason_d;
            tracing_q     <= (state_d != LC_IDLE);
        end
    end

    assign cnt_clear = handshake && ((state_q == LC_START_PEND) ||
                       ((state_q == LC_RESYNC_PEND) && (state_d == LC_TRACING)));
    assign cnt_inc   = (state_q == LC_TRACING) && inst_valid_i && (resync_cnt_q < resync_max_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resync_cnt_q <= '0;
        end else if (cnt_clear) begin
            resync_cnt_q <= '0;
        end else if (cnt_inc) begin
            resync_cnt_q <= resync_cnt_q + RESYNC_W'(1);
        end
    end

    assign sync_valid_o  = sync_valid_q;
    assign sync_reason_o = sync_reason_q;
    assign tracing_o     = tracing_q;
    assign resync_cnt_o  = resync_cnt_q;

endmodule
